// File: rtl/sfx_pkg.sv
// Shared types and constants for the tone scheduler: FSM states, timing
// defaults and note half-periods at a 50 MHz system clock.
package sfx_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam int TICK_DIV_DEF = 6250000;
    localparam int GAP_CYC_DEF  = 250000;

    localparam int HP_C5 = 47778;
    localparam int HP_D5 = 42565;
    localparam int HP_E5 = 37921;
    localparam int HP_G5 = 31888;
    localparam int HP_A5 = 28409;
    localparam int HP_B5 = 25309;
    localparam int HP_C6 = 23889;
    localparam int HP_F6 = 17896;

endpackage

// File: rtl/sfx_scheduler_if.sv
// Requester-side bundle of the tone scheduler: note requests in, grant /
// completion pulses and the speaker output back.
interface sfx_if #(
    parameter int NREQ  = 4,
    parameter int HP_W  = 18,
    parameter int DUR_W = 8
);
    localparam int ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*HP_W-1:0]  half_period;
    logic [NREQ*DUR_W-1:0] duration;
    logic [NREQ-1:0]       grant;
    logic [NREQ-1:0]       done;
    logic [NREQ-1:0]       abort;
    logic                  busy;
    logic [ID_W-1:0]       active_id;
    logic                  signalout;

    modport master (
        output req, half_period, duration,
        input  grant, done, abort, busy, active_id, signalout
    );

    modport slave (
        input  req, half_period, duration,
        output grant, done, abort, busy, active_id, signalout
    );

endinterface

// File: rtl/sfx_scheduler_square_tone.sv
// Square-wave generator: toggles every half_period clocks, held low on
// restart or when half_period is 0 (a rest).
module square_tone #(
    parameter int HP_W = 18
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    input  logic [HP_W-1:0] half_period,
    output logic            out
);

    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            out_q, out_d;

    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (restart || half_period == '0) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else if (cnt_q == half_period - HP_W'(1)) begin
            cnt_d = '0;
            out_d = ~out_q;
        end else begin
            cnt_d = cnt_q + HP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/sfx_scheduler.sv
// Fixed-priority tone scheduler: grants one note at a time, times it in beat
// ticks, lets higher-priority requesters preempt, and inserts a silent gap.
//
//  state  | meaning
//  S_IDLE | no note; lowest-index request is granted on the next edge
//  S_PLAY | note sounding; tick/remaining counters run, preemption allowed
//  S_GAP  | silent articulation gap after a completed note
module sfx_scheduler
    import sfx_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int HP_W     = 18,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int GAP_CYC  = GAP_CYC_DEF
) (
    input logic clk,
    input logic rst,
    sfx_if.slave bus
);

    localparam int ID_W   = $clog2(NREQ);
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W  = $clog2(GAP_CYC + 1);

    state_t          state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] abort_q, abort_d;

    logic            win_vld;
    logic [ID_W-1:0] win_id;
    logic [HP_W-1:0] win_hp;
    logic [DUR_W-1:0] win_dur;
    logic            start_note;
    logic            tone_restart;

    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(i);
            end
        end
    end

    assign win_hp  = bus.half_period[int'(win_id)*HP_W +: HP_W];
    assign win_dur = bus.duration[int'(win_id)*DUR_W +: DUR_W];

    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        hp_d         = hp_q;
        rem_d        = rem_q;
        tick_d       = tick_q;
        gap_d        = gap_q;
        grant_d      = '0;
        done_d       = '0;
        abort_d      = '0;
        start_note   = 1'b0;
        tone_restart = (state_q != S_PLAY);

        case (state_q)
            S_IDLE: begin
                start_note = win_vld;
            end
            S_PLAY: begin
                // Preemption wins over a note finishing on the same edge.
                if (win_vld && win_id < id_q) begin
                    start_note      = 1'b1;
                    abort_d[id_q]   = 1'b1;
                end else if (tick_q == TICK_W'(TICK_DIV - 1)) begin
                    tick_d = '0;
                    rem_d  = rem_q - DUR_W'(1);
                    if (rem_q == DUR_W'(1)) begin
                        done_d[id_q] = 1'b1;
                        tone_restart = 1'b1;
                        gap_d        = '0;
                        state_d      = S_GAP;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYC - 1)) begin
                    if (win_vld) begin
                        start_note = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        id_d    = '0;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                id_d    = '0;
            end
        endcase

        if (start_note) begin
            state_d         = S_PLAY;
            grant_d[win_id] = 1'b1;
            id_d            = win_id;
            hp_d            = win_hp;
            rem_d           = (win_dur == '0) ? DUR_W'(1) : win_dur;
            tick_d          = '0;
            tone_restart    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            hp_q    <= '0;
            rem_q   <= '0;
            tick_q  <= '0;
            gap_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            hp_q    <= hp_d;
            rem_q   <= rem_d;
            tick_q  <= tick_d;
            gap_q   <= gap_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    square_tone #(.HP_W(HP_W)) u_tone (
        .clk         (clk),
        .rst         (rst),
        .restart     (tone_restart),
        .half_period (hp_q),
        .out         (bus.signalout)
    );

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.abort     = abort_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.active_id = id_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Bench for sfx_scheduler: scenario table plus random scenarios, each checked
// cycle by cycle against a timeline model of grants, notes and gaps.
module tb_sfx_scheduler;
    import sfx_pkg::*;

    localparam int NREQ = 4;
    localparam int HP_W = 18;
    localparam int DUR_W = 8;
    localparam int TD = 10;
    localparam int GC = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sfx_if #(.NREQ(NREQ), .HP_W(HP_W), .DUR_W(DUR_W)) bus ();

    sfx_scheduler #(
        .NREQ(NREQ), .HP_W(HP_W), .DUR_W(DUR_W), .TICK_DIV(TD), .GAP_CYC(GC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // id/hp/dur: first note; pid<0 means no second requester; t_r is the
    // cycle (relative to the first grant) after which req[pid] rises, -1 = together.
    typedef struct {
        int id; int hp; int dur; int t_r; int pid; int php; int pdur;
    } scen_t;

    scen_t tbl[8];

    function automatic logic [15:0] outs();
        return {bus.grant, bus.done, bus.abort, bus.busy, bus.active_id, bus.signalout};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic tone(input int hp, input int t);
        if (hp == 0) return 1'b0;
        return ((t / hp) % 2) != 0;
    endfunction

    function automatic int note_len(input int dur);
        return ((dur == 0) ? 1 : dur) * TD;
    endfunction

    task automatic run_scen(input int sn, input scen_t s);
        int l1, l2, s2, last, end1, busy1_end;
        bit have2, pre;
        logic [NREQ-1:0] eg, ed, ea;
        logic es, eb;
        int eid;
        l1 = note_len(s.dur);
        have2 = (s.pid >= 0);
        pre = 1'b0;
        s2 = -1000;
        l2 = 0;
        if (have2) begin
            l2 = note_len(s.pdur);
            if (s.pid < s.id && s.t_r >= 0 && s.t_r < l1) begin
                pre = 1'b1;
                s2 = s.t_r + 1;
            end else if (s.t_r <= l1 + GC - 1) begin
                s2 = l1 + GC;
            end else begin
                s2 = s.t_r + 1;
            end
        end
        last = have2 ? s2 + l2 + GC + 2 : l1 + GC + 2;
        end1 = pre ? s2 : l1;
        busy1_end = pre ? s2 : l1 + GC;

        bus.half_period[s.id*HP_W +: HP_W] = HP_W'(s.hp);
        bus.duration[s.id*DUR_W +: DUR_W] = DUR_W'(s.dur);
        if (have2) begin
            bus.half_period[s.pid*HP_W +: HP_W] = HP_W'(s.php);
            bus.duration[s.pid*DUR_W +: DUR_W] = DUR_W'(s.pdur);
        end
        bus.req[s.id] = 1'b1;
        if (have2 && s.t_r < 0) bus.req[s.pid] = 1'b1;

        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            eg = '0; ed = '0; ea = '0; es = 1'b0; eb = 1'b0; eid = 0;
            if (c == 0) eg[s.id] = 1'b1;
            if (!pre && c == l1) ed[s.id] = 1'b1;
            if (pre && c == s2) ea[s.id] = 1'b1;
            if (c < end1) es = tone(s.hp, c);
            if (c < busy1_end) begin eb = 1'b1; eid = s.id; end
            if (have2) begin
                if (c == s2) eg[s.pid] = 1'b1;
                if (c == s2 + l2) ed[s.pid] = 1'b1;
                if (c >= s2 && c < s2 + l2) es = tone(s.php, c - s2);
                if (c >= s2 && c < s2 + l2 + GC) begin eb = 1'b1; eid = s.pid; end
            end
            chk($sformatf("scen%0d cyc%0d {grant,done,abort,busy,id,out}", sn, c),
                outs(), {eg, ed, ea, eb, 2'(eid), es});
            if (c == 0) bus.req[s.id] = 1'b0;
            if (have2 && c == s2) bus.req[s.pid] = 1'b0;
            if (have2 && c == s.t_r) bus.req[s.pid] = 1'b1;
        end
    endtask

    initial begin
        scen_t r;
        rst = 1'b1;
        bus.req = '0;
        bus.half_period = '0;
        bus.duration = '0;

        tbl[0] = '{2, 4, 3, 0, -1, 0, 0};    // single note
        tbl[1] = '{1, 5, 1, -1, 3, 2, 1};    // simultaneous 1 and 3
        tbl[2] = '{3, 4, 3, 12, 0, 3, 1};    // preemption 12 clocks in
        tbl[3] = '{1, 0, 2, 0, -1, 0, 0};    // rest
        tbl[4] = '{0, 3, 0, 0, -1, 0, 0};    // zero length
        tbl[5] = '{1, 2, 2, 5, 2, 3, 1};     // lower priority waits for gap end
        tbl[6] = '{2, 2, 1, 11, 0, 1, 1};    // higher priority during gap waits
        tbl[7] = '{3, 1, 1, 14, 1, 2, 1};    // request arriving in idle

        repeat (2) @(negedge clk);
        chk("reset_state", outs(), 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        foreach (tbl[i]) run_scen(i, tbl[i]);

        for (int k = 0; k < 20; k++) begin
            r.id = $urandom_range(0, NREQ - 1);
            r.hp = $urandom_range(0, 6);
            r.dur = $urandom_range(0, 3);
            r.pid = -1;
            r.t_r = 0;
            r.php = $urandom_range(0, 6);
            r.pdur = $urandom_range(0, 2);
            if ($urandom_range(0, 3) != 0) begin
                r.pid = (r.id + $urandom_range(1, NREQ - 1)) % NREQ;
                r.t_r = $urandom_range(0, note_len(r.dur) + GC + 3) - 1;
                if (r.t_r < 0 && r.pid < r.id) r.t_r = 0;
                if (r.pid < r.id && r.t_r == note_len(r.dur) - 1) r.t_r++;
            end
            run_scen(100 + k, r);
        end

        // Reset in the middle of a note with the requester still holding req.
        bus.half_period[1*HP_W +: HP_W] = HP_W'(3);
        bus.duration[1*DUR_W +: DUR_W] = DUR_W'(2);
        bus.req[1] = 1'b1;
        @(negedge clk);
        chk("rst_seq grant", outs(), {4'b0010, 4'b0, 4'b0, 1'b1, 2'd1, 1'b0});
        repeat (6) @(negedge clk);
        chk("rst_seq busy before reset", {15'b0, bus.busy}, 16'h0001);
        #1 rst = 1'b1;
        #1 chk("async_reset outputs", outs(), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("grant_after_release", outs(), {4'b0010, 4'b0, 4'b0, 1'b1, 2'd1, 1'b0});
        bus.req[1] = 1'b0;
        repeat (2 * TD + GC + 1) @(negedge clk);
        chk("idle_after_note", outs(), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sfx_scheduler.md
# sfx_scheduler

Shares the single square-wave tone output between up to NREQ sound requesters (background melody sequencer, game-event sound effects). Each requester asks for one note (half-period in clocks, length in beat ticks). A fixed-priority arbiter grants the note, times it, and drives the speaker pin. A higher-priority request preempts the note in progress. The block sits between the game/music logic and the board's audio output pin.

## Interface
- NREQ, 4: number of requesters; index 0 has the highest priority.
- HP_W, 18: half-period width in clocks (covers 47778 = C5 at 50 MHz).
- DUR_W, 8: note length width, in beat ticks.
- TICK_DIV, 6250000: clocks per beat tick (1/8 s at 50 MHz).
- GAP_CYC, 250000: silent articulation gap after a completed note, in clocks.
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset; asynchronous, active-high.
- req  in  NREQ  level request, one bit per requester.
- half_period  in  NREQ*HP_W  requester i at [i*HP_W +: HP_W]; 0 = rest.
- duration  in  NREQ*DUR_W  requester i at [i*DUR_W +: DUR_W]; 0 is treated as 1.
- grant  out  NREQ  one-cycle pulse: the note has been accepted and its inputs latched.
- done  out  NREQ  one-cycle pulse: the note completed its full length.
- abort  out  NREQ  one-cycle pulse: the note was preempted.
- busy  out  1  high in PLAY and GAP.
- active_id  out  $clog2(NREQ)  index of the requester being played; 0 when idle.
- signalout  out  1  square wave to the speaker.

## Operation
- States are IDLE, PLAY and GAP. Reset: state IDLE, and every output is 0.
- IDLE: the lowest-index asserted req wins.
  - Registered, on that edge: grant[winner]=1; latch half_period and duration (0 becomes 1); active_id=winner; clear the tick and tone counters; enter PLAY.
- PLAY:
  - The tone counter counts 0..half_period-1 and toggles signalout at the wrap. Period is 2*half_period clocks. signalout starts at 0.
  - half_period=0 holds signalout at 0 (rest).
  - The tick counter counts 0..TICK_DIV-1. At each wrap, remaining decrements.
  - When remaining reaches 0: done[active_id]=1, signalout=0, enter GAP.
- Preemption (PLAY only): if req[j] is asserted with j < active_id, then on one edge:
  - abort[active_id]=1 and grant[j]=1;
  - relatch j's inputs and restart both counters with signalout=0;
  - stay in PLAY. No done is issued for the aborted note.
- req[active_id] and lower-priority requests are ignored during PLAY.
- GAP: signalout=0 for GAP_CYC clocks, then IDLE. A request arriving during GAP waits. Preemption does not apply in GAP.
- Requester contract:
  - hold req and the note inputs stable until grant is seen;
  - deassert req in the cycle grant is observed;
  - a req still high at a later arbitration is a new request.
- Reset mid-note: everything clears asynchronously. After release, held requests arbitrate normally from IDLE.

## Timing
- Grant latency: req high before edge k gives grant high for the cycle after edge k.
- Note length: exactly duration*TICK_DIV clocks from the grant cycle to the done cycle.
- busy falls GAP_CYC clocks after done.
- The next grant is possible on the edge where busy falls.
- grant, done and abort are single-cycle. At most one grant and one of done/abort occur per cycle.
- Width rules:
  - counters are unsigned, with no overflow at the maximum parameters;
  - tick counter width is $clog2(TICK_DIV);
  - remaining is DUR_W bits.

## Structure
- Package sfx_pkg holds:
  - the state enum;
  - defaults for TICK_DIV and GAP_CYC;
  - named half-period constants at 50 MHz: C5=47778, D5=42565, E5=37921, G5=31888, A5=28409, B5=25309, C6=23889, F6=17896.
- Sub-module square_tone: inputs clk, rst, restart, half_period; output out. It contains the tone counter and the toggle, and holds out at 0 when half_period=0.
- sfx_scheduler holds the arbiter, the FSM, the tick/duration counters and the pulse outputs.

## Test plan
Sim parameters: TICK_DIV=10, GAP_CYC=3.
- Single note: req[2] with hp=4, dur=3 gives:
  - grant[2] one cycle later;
  - signalout period 8 clocks, first rising edge 4 clocks after grant;
  - done[2] exactly 30 clocks after grant;
  - busy low 3 clocks after done.
- Simultaneous requests: req[1] and req[3] high together in IDLE give:
  - grant[1] only;
  - req[3] stays held and grant[3] arrives on the cycle busy falls.
- Preemption: req[0] raised 12 clocks into req[3]'s note gives:
  - abort[3] and grant[0] in the same cycle;
  - signalout restarts at 0;
  - active_id=0;
  - no done[3].
- Rest and zero length:
  - hp=0, dur=2: signalout stays 0 and done arrives at 20 clocks;
  - dur=0: done arrives at 10 clocks.
- Reset mid-note: rst asserted mid-PLAY gives:
  - all outputs 0 immediately, without waiting for a clock edge;
  - with req[1] still held, grant[1] one cycle after release.
